// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_if
// Description : AXI4-Stream style word handshake feeding the UART transmitter.
// Revision    : 1.0  initial release
// ============================================================================
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : AXI4-Stream to UART transmitter, 8N1 by default, bit period
//               prescale*8 clocks. Optional parity via UART_TX_PARITY_EN.
// Revision    : 1.0  initial release
// ============================================================================
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    uart_tx_if.slave    s_axis,
    output logic        txd,
    output logic        busy,
    input  logic [15:0] prescale
`ifdef UART_TX_PARITY_EN
    ,
    input  logic [1:0]  parity_mode
`endif
);

    localparam logic [3:0] c_LAST_BIT = 4'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state, w_state;
    logic [DATA_WIDTH-1:0] r_shift, w_shift;
    logic [18:0]           r_bit_len, w_bit_len;
    logic [18:0]           r_cnt, w_cnt;
    logic [3:0]            r_bits, w_bits;
    logic                  r_tready, w_tready;
    logic                  r_busy, w_busy;
    logic                  r_txd, w_txd;
`ifdef UART_TX_PARITY_EN
    logic                  r_par, w_par;
    logic                  r_par_en, w_par_en;
`endif

    logic [15:0]           w_ps;
    logic [18:0]           w_len_in;
    logic                  w_cnt_zero;

    // prescale of zero would stall the bit counter, so it behaves as one
    assign w_ps       = (prescale == 16'd0) ? 16'd1 : prescale;
    assign w_len_in   = {w_ps, 3'b000};
    assign w_cnt_zero = (r_cnt == 19'd0);

    always_comb begin
        w_state   = r_state;
        w_shift   = r_shift;
        w_bit_len = r_bit_len;
        w_cnt     = r_cnt;
        w_bits    = r_bits;
        w_tready  = r_tready;
        w_busy    = r_busy;
        w_txd     = r_txd;
`ifdef UART_TX_PARITY_EN
        w_par     = r_par;
        w_par_en  = r_par_en;
`endif
        case (r_state)
            S_IDLE: begin
                w_tready = 1'b1;
                w_busy   = 1'b0;
                w_txd    = 1'b1;
                if (r_tready && s_axis.tvalid) begin
                    w_state   = S_START;
                    w_shift   = s_axis.tdata;
                    w_bit_len = w_len_in;
                    w_cnt     = w_len_in - 19'd1;
                    w_tready  = 1'b0;
                    w_busy    = 1'b1;
                    w_txd     = 1'b0;
`ifdef UART_TX_PARITY_EN
                    w_par     = (^s_axis.tdata) ^ (parity_mode == 2'b10);
                    w_par_en  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
`endif
                end
            end
            S_START: begin
                if (w_cnt_zero) begin
                    w_state = S_DATA;
                    w_txd   = r_shift[0];
                    w_shift = r_shift >> 1;
                    w_bits  = c_LAST_BIT;
                    w_cnt   = r_bit_len - 19'd1;
                end else begin
                    w_cnt = r_cnt - 19'd1;
                end
            end
            S_DATA: begin
                if (w_cnt_zero) begin
                    w_cnt = r_bit_len - 19'd1;
                    // r_bits counts the bits still to follow the one on the line
                    if (r_bits == 4'd0) begin
`ifdef UART_TX_PARITY_EN
                        if (r_par_en) begin
                            w_state = S_PARITY;
                            w_txd   = r_par;
                        end else
`endif
                        begin
                            w_state = S_STOP;
                            w_txd   = 1'b1;
                        end
                    end else begin
                        w_txd   = r_shift[0];
                        w_shift = r_shift >> 1;
                        w_bits  = r_bits - 4'd1;
                    end
                end else begin
                    w_cnt = r_cnt - 19'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_cnt_zero) begin
                    w_state = S_STOP;
                    w_txd   = 1'b1;
                    w_cnt   = r_bit_len - 19'd1;
                end else begin
                    w_cnt = r_cnt - 19'd1;
                end
            end
`endif
            S_STOP: begin
                if (w_cnt_zero) begin
                    w_state  = S_IDLE;
                    w_tready = 1'b1;
                    w_busy   = 1'b0;
                    w_txd    = 1'b1;
                end else begin
                    w_cnt = r_cnt - 19'd1;
                end
            end
            default: begin
                w_state  = S_IDLE;
                w_tready = 1'b0;
                w_busy   = 1'b0;
                w_txd    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_len <= '0;
            r_cnt     <= '0;
            r_bits    <= '0;
            r_tready  <= 1'b0;
            r_busy    <= 1'b0;
            r_txd     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par     <= 1'b0;
            r_par_en  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state;
            r_shift   <= w_shift;
            r_bit_len <= w_bit_len;
            r_cnt     <= w_cnt;
            r_bits    <= w_bits;
            r_tready  <= w_tready;
            r_busy    <= w_busy;
            r_txd     <= w_txd;
`ifdef UART_TX_PARITY_EN
            r_par     <= w_par;
            r_par_en  <= w_par_en;
`endif
        end
    end

    assign s_axis.tready = r_tready;
    assign txd           = r_txd;
    assign busy          = r_busy;

endmodule
`default_nettype wire
